// File: rtl/axi_pkg.sv
// Shared AXI read-path constants, encodings and types.
package axi_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned IDS_WIDTH  = 8;
  localparam int unsigned LEN_WIDTH  = 4;

  // Upper slave-ID bits that carry the master index.
  localparam int unsigned ID_PAD = IDS_WIDTH - ID_WIDTH;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  // Slave-side read address payload.
  typedef struct packed {
    logic [IDS_WIDTH-1:0]  id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } ar_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: sole requester wins, ties go to prio.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  logic       done_id,
  output logic       grant,
  output logic       prio
);

  // Grant candidate from the current request pair.
  always_comb begin
    grant = prio;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = prio;
    endcase
  end

  // Priority passes to the other master once a burst completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (done) begin
      prio <= ~done_id;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read slave between two masters, one burst in flight.
module axi_read_arbiter
  import axi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   ARID_M0,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M0,
  input  logic [LEN_WIDTH-1:0]  ARLEN_M0,
  input  logic [2:0]            ARSIZE_M0,
  input  logic [1:0]            ARBURST_M0,
  input  logic                  ARVALID_M0,
  output logic                  ARREADY_M0,
  input  logic [ID_WIDTH-1:0]   ARID_M1,
  input  logic [ADDR_WIDTH-1:0] ARADDR_M1,
  input  logic [LEN_WIDTH-1:0]  ARLEN_M1,
  input  logic [2:0]            ARSIZE_M1,
  input  logic [1:0]            ARBURST_M1,
  input  logic                  ARVALID_M1,
  output logic                  ARREADY_M1,
  output logic [IDS_WIDTH-1:0]  ARID_S,
  output logic [ADDR_WIDTH-1:0] ARADDR_S,
  output logic [LEN_WIDTH-1:0]  ARLEN_S,
  output logic [2:0]            ARSIZE_S,
  output logic [1:0]            ARBURST_S,
  output logic                  ARVALID_S,
  input  logic                  ARREADY_S,
  input  logic [IDS_WIDTH-1:0]  RID_S,
  input  logic [DATA_WIDTH-1:0] RDATA_S,
  input  logic [1:0]            RRESP_S,
  input  logic                  RLAST_S,
  input  logic                  RVALID_S,
  output logic                  RREADY_S,
  output logic [ID_WIDTH-1:0]   RID_M0,
  output logic [DATA_WIDTH-1:0] RDATA_M0,
  output logic [1:0]            RRESP_M0,
  output logic                  RLAST_M0,
  output logic                  RVALID_M0,
  input  logic                  RREADY_M0,
  output logic [ID_WIDTH-1:0]   RID_M1,
  output logic [DATA_WIDTH-1:0] RDATA_M1,
  output logic [1:0]            RRESP_M1,
  output logic                  RLAST_M1,
  output logic                  RVALID_M1,
  input  logic                  RREADY_M1
);

  state_t state, state_next;
  logic   gnt, gnt_q, prio;
  logic   ar_hs, r_done;
  ar_t    ar_sel, ar_q;
  logic   arvalid_q;
  logic [ID_PAD-1:0] unused_rid_hi;

  assign unused_rid_hi = RID_S[IDS_WIDTH-1:ID_WIDTH];

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({ARVALID_M1, ARVALID_M0}),
    .done    (r_done),
    .done_id (gnt_q),
    .grant   (gnt),
    .prio    (prio)
  );

  // Master handshake in IDLE and last-beat handshake in DATA.
  assign ar_hs  = (state == IDLE) && (gnt ? ARVALID_M1 : ARVALID_M0);
  assign r_done = (state == DATA) && RVALID_S && RLAST_S &&
                  (gnt_q ? RREADY_M1 : RREADY_M0);

  // Candidate request in slave form; master index goes into the upper ID bits.
  always_comb begin
    ar_sel       = '0;
    ar_sel.id    = {ID_PAD'(gnt), (gnt ? ARID_M1 : ARID_M0)};
    ar_sel.addr  = gnt ? ARADDR_M1  : ARADDR_M0;
    ar_sel.len   = gnt ? ARLEN_M1   : ARLEN_M0;
    ar_sel.size  = gnt ? ARSIZE_M1  : ARSIZE_M0;
    ar_sel.burst = gnt ? ARBURST_M1 : ARBURST_M0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, master AR ready and R-channel routing.
  always_comb begin
    state_next = state;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RREADY_S   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M1  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    unique case (state)
      IDLE: begin
        ARREADY_M0 = !rst && ARVALID_M0 && !gnt;
        ARREADY_M1 = !rst && ARVALID_M1 && gnt;
        if (ar_hs) state_next = ADDR;
      end
      ADDR: begin
        if (ARREADY_S) state_next = DATA;
      end
      DATA: begin
        if (gnt_q) begin
          RREADY_S  = RREADY_M1;
          RVALID_M1 = RVALID_S;
          RID_M1    = RID_S[ID_WIDTH-1:0];
          RDATA_M1  = RDATA_S;
          RRESP_M1  = RRESP_S;
          RLAST_M1  = RLAST_S;
        end else begin
          RREADY_S  = RREADY_M0;
          RVALID_M0 = RVALID_S;
          RID_M0    = RID_S[ID_WIDTH-1:0];
          RDATA_M0  = RDATA_S;
          RRESP_M0  = RRESP_S;
          RLAST_M0  = RLAST_S;
        end
        if (r_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the granted request; AR outputs hold until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q      <= '0;
      gnt_q     <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      arvalid_q <= (state_next == ADDR);
      if (ar_hs) begin
        ar_q  <= ar_sel;
        gnt_q <= gnt;
      end
    end
  end

  assign ARID_S    = ar_q.id;
  assign ARADDR_S  = ar_q.addr;
  assign ARLEN_S   = ar_q.len;
  assign ARSIZE_S  = ar_q.size;
  assign ARBURST_S = ar_q.burst;
  assign ARVALID_S = arvalid_q;

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

- Shares one AXI4 read slave port between the CPU wrapper's two read masters: M0 (instruction fetch) and M1 (data).
- Arbitrates the AR channel round-robin and forwards the granted address, with the ID widened to IDS_WIDTH, to the slave.
- Routes the R channel back to the granted master.
- Allows one outstanding read burst at a time and sits between CPU_wrapper and the memory-side slave.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- ID_WIDTH, 4, master ID width
- IDS_WIDTH, 8, slave ID width; must be ≥ ID_WIDTH+1
- LEN_WIDTH, 4, burst length width
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- ARID_M0/ARID_M1 in, ARID_S out  ID_WIDTH / IDS_WIDTH  read address ID
- ARADDR_M0/M1 in, ARADDR_S out  ADDR_WIDTH  read address
- ARLEN_M0/M1 in, ARLEN_S out  LEN_WIDTH  burst length minus one
- ARSIZE_M0/M1 in, ARSIZE_S out  3  beat size
- ARBURST_M0/M1 in, ARBURST_S out  2  burst type
- ARVALID_M0/M1 in, ARVALID_S out  1  address valid
- ARREADY_M0/M1 out, ARREADY_S in  1  address ready
- RID_S in, RID_M0/M1 out  IDS_WIDTH / ID_WIDTH  read ID
- RDATA_S in, RDATA_M0/M1 out  DATA_WIDTH  read data
- RRESP_S in, RRESP_M0/M1 out  2  read response
- RLAST_S in, RLAST_M0/M1 out  1  last beat
- RVALID_S in, RVALID_M0/M1 out  1  read valid
- RREADY_M0/M1 in, RREADY_S out  1  read ready

## Operation
- FSM states:
  - IDLE: ARREADY_Mg = 1 for the grant candidate g only.
  - ADDR: ARVALID_S = 1; fields come from the capture register.
  - DATA: the R channel is connected to master g.
- IDLE grant selection:
  - Only one ARVALID_Mx high → g = x.
  - Both high → g = prio.
  - prio resets to M0.
  - ARREADY_Mx = (state==IDLE) && (g==x) && ARVALID_Mx.
- IDLE → ADDR on the master handshake. Capture:
  - ARADDR, ARLEN, ARSIZE, ARBURST
  - ARID_S = {(IDS_WIDTH-ID_WIDTH) bits holding g zero-extended, ARID_Mg}
  - grant register = g
- ADDR → DATA when ARREADY_S is high. ARVALID_S then drops, and the AR outputs hold their values until the next capture.
- DATA:
  - RVALID_Mg = RVALID_S, RREADY_S = RREADY_Mg.
  - RDATA/RRESP/RLAST pass through; RID_Mg = RID_S[ID_WIDTH-1:0].
  - The non-granted master sees RVALID = 0.
- DATA → IDLE on RVALID_S && RREADY_S && RLAST_S; prio becomes the non-granted master.
- An RVALID_S outside DATA is a protocol error: RREADY_S = 0 and the beat is not forwarded.

## Timing
- Reset values:
  - state IDLE, prio M0
  - ARVALID_S 0, ARREADY_M0/M1 0, RVALID_M0/M1 0, RREADY_S 0
  - ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S all 0
  - RID/RDATA/RRESP/RLAST_M0/M1 0
- ARREADY_Mx and all R signals are combinational from state; AR outputs to the slave are registered.
- Latency and throughput:
  - Master handshake at edge N → ARVALID_S high from cycle N+1.
  - Minimum 1 idle cycle between RLAST and the next ARREADY_Mx.
- Rules:
  - ARVALID_S never deasserts before ARREADY_S.
  - A request that loses arbitration is held by its master and wins the next IDLE grant.
- Simultaneous events:
  - Last-beat handshake and new ARVALID in the same cycle: the new request is granted in the following IDLE cycle.
  - ARREADY_S high on the first ADDR cycle: exactly one slave handshake.
- Reset mid-burst: immediate return to IDLE with reset values; in-flight data is dropped.

## Structure
- Shared package axi_pkg:
  - AXI width constants (ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, IDS_WIDTH, LEN_WIDTH)
  - burst/resp encodings
  - state typedef {IDLE, ADDR, DATA}
- Sub-module rr_arbiter2 (2-way round-robin):
  - inputs: req[1:0], done, done_id
  - outputs: grant index, prio register
- Everything else stays flat in axi_read_arbiter.

## Test plan
- M0 only: ARVALID_M0=1, ARADDR 0x0000_0100, ARLEN 3, ARID 2, slave ARREADY delayed 2 cycles.
  - Slave sees ARID_S 0x02, held stable until ARREADY_S.
  - 4 beats reach M0; RID_M0 = 2; RVALID_M1 stays 0.
- Both valid from reset, ARADDR_M0 0x10 / ARADDR_M1 0x20:
  - Order: M0 served first, M1 second.
  - Then a simultaneous pair: M0 first again, because prio returned to M0 after M1 was served.
- Back-to-back M1 with M0 idle: the second request is granted one IDLE cycle after RLAST; ARID_S upper bits = 1.
- R backpressure: RREADY_M1 toggles 1,0,1,0 during ARLEN 1.
  - RREADY_S mirrors it.
  - Exactly 2 beats transferred; return to IDLE only after the RLAST handshake.
- Reset asserted in DATA after 2 of 4 beats: all outputs 0 the same cycle.
  - After release, an M1 request is granted first in IDLE (prio = M0 but only M1 valid).
- Stray RVALID_S in IDLE: RREADY_S stays 0, RVALID_M0/M1 stay 0.
